// File: rtl/i2c_cfg_pkg.sv
// rtl/i2c_cfg_pkg.sv - Shared types and constants for the SCCB command arbiter.
package i2c_cfg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_XFER    = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_t;

    localparam int I2C_CMD_W = 32;

    localparam logic [7:0] OV5640_WADDR  = 8'h78;
    localparam logic [7:0] HDMI_TX_WADDR = 8'h72;

    // Command layout: {dev_addr, reg_hi, reg_lo, value}
    localparam int CMD_DEV_LSB   = 24;
    localparam int CMD_REGHI_LSB = 16;
    localparam int CMD_REGLO_LSB = 8;
    localparam int CMD_VAL_LSB   = 0;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - Combinational round-robin picker: first set mask bit at or after ptr, wrapping.
module rr_pick #(
    parameter int N = 2,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] i_mask,
    input  logic [W-1:0] i_ptr,
    output logic [N-1:0] o_onehot,
    output logic [W-1:0] o_idx,
    output logic         o_any
);

    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_any    = 1'b0;
        // Walk from farthest to nearest so the candidate closest to ptr is written last.
        for (int k = N - 1; k >= 0; k--) begin
            if (i_mask[(int'(i_ptr) + k) % N]) begin
                o_onehot                           = '0;
                o_onehot[(int'(i_ptr) + k) % N]    = 1'b1;
                o_idx                              = W'((int'(i_ptr) + k) % N);
                o_any                              = 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_cmd_arbiter.sv
// rtl/i2c_cmd_arbiter.sv - Round-robin arbiter sharing the i2c_com write engine with per-transfer timeout.
module i2c_cmd_arbiter
    import i2c_cfg_pkg::*;
#(
    parameter int NREQ        = 2,
    parameter int TIMEOUT_CYC = 2048,
    parameter int GW          = $clog2(NREQ)
) (
    input  logic                        clock_20k,
    input  logic                        camera_rst,
    input  logic [NREQ-1:0]             req_valid,
    input  logic [I2C_CMD_W*NREQ-1:0]   req_data,
    input  logic [NREQ-1:0]             req_lock,
    output logic [NREQ-1:0]             req_ready,
    output logic [NREQ-1:0]             resp_valid,
    output logic                        resp_err,
    output logic                        resp_timeout,
    output logic                        busy,
    output logic [GW-1:0]               grant,
    output logic                        start,
    output logic [I2C_CMD_W-1:0]        i2c_data,
    input  logic                        tr_end,
    input  logic                        ack
);

    localparam int              TW       = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0]   TMO_MAX  = '1;

    arb_state_t             r_state;
    logic [GW-1:0]          r_rr_ptr;
    logic [GW-1:0]          r_grant;
    logic                   r_lock;
    logic [TW-1:0]          r_tmo_cnt;
    logic                   r_start;
    logic [I2C_CMD_W-1:0]   r_i2c_data;
    logic [NREQ-1:0]        r_resp_valid;
    logic                   r_resp_err;
    logic                   r_resp_timeout;
    logic                   r_busy;

    logic [NREQ-1:0]        w_grant_oh;
    logic                   w_owner_lock;
    logic                   w_lock_eff;
    logic [NREQ-1:0]        w_mask;
    logic [NREQ-1:0]        w_win_oh;
    logic [GW-1:0]          w_win_idx;
    logic                   w_any;
    logic [GW-1:0]          w_next_ptr;
    logic [I2C_CMD_W-1:0]   w_win_data;

    // A held lock only counts while the owner still asserts req_lock, so release is immediate.
    assign w_grant_oh   = NREQ'(1) << r_grant;
    assign w_owner_lock = req_lock[r_grant];
    assign w_lock_eff   = r_lock & w_owner_lock;
    assign w_mask       = w_lock_eff ? (req_valid & w_grant_oh) : req_valid;
    assign w_next_ptr   = (w_win_idx == GW'(NREQ - 1)) ? '0 : w_win_idx + GW'(1);
    assign w_win_data   = req_data[int'(w_win_idx) * I2C_CMD_W +: I2C_CMD_W];

    rr_pick #(
        .N (NREQ),
        .W (GW)
    ) u_rr_pick (
        .i_mask   (w_mask),
        .i_ptr    (r_rr_ptr),
        .o_onehot (w_win_oh),
        .o_idx    (w_win_idx),
        .o_any    (w_any)
    );

    assign req_ready    = (r_state == ST_IDLE) ? w_win_oh : '0;
    assign resp_valid   = r_resp_valid;
    assign resp_err     = r_resp_err;
    assign resp_timeout = r_resp_timeout;
    assign busy         = r_busy;
    assign grant        = r_grant;
    assign start        = r_start;
    assign i2c_data     = r_i2c_data;

    always_ff @(posedge clock_20k or posedge camera_rst) begin
        if (camera_rst) begin
            r_state        <= ST_IDLE;
            r_rr_ptr       <= '0;
            r_grant        <= '0;
            r_lock         <= 1'b0;
            r_tmo_cnt      <= '0;
            r_start        <= 1'b0;
            r_i2c_data     <= '0;
            r_resp_valid   <= '0;
            r_resp_err     <= 1'b0;
            r_resp_timeout <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_resp_valid <= '0;
                    if (r_lock && !w_owner_lock) begin
                        r_lock <= 1'b0;
                    end
                    if (w_any) begin
                        r_i2c_data <= w_win_data;
                        r_grant    <= w_win_idx;
                        r_rr_ptr   <= w_next_ptr;
                        r_start    <= 1'b1;
                        r_tmo_cnt  <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (r_tmo_cnt != TMO_MAX) begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
                    if (tr_end) begin
                        r_start        <= 1'b0;
                        r_resp_err     <= ack;
                        r_resp_timeout <= 1'b0;
                        r_resp_valid   <= w_grant_oh;
                        r_state        <= ST_RELEASE;
                    end else if (r_tmo_cnt == TMO_LAST) begin
                        r_start        <= 1'b0;
                        r_resp_err     <= 1'b1;
                        r_resp_timeout <= 1'b1;
                        r_resp_valid   <= w_grant_oh;
                        r_state        <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    r_resp_valid <= '0;
                    // The response pulse marks the first RELEASE cycle.
                    if (|r_resp_valid) begin
                        r_lock <= w_owner_lock;
                    end
                    if (!tr_end) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_start      <= 1'b0;
                    r_resp_valid <= '0;
                    r_busy       <= 1'b0;
                    r_state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
